sobel_window_ctrl: RTL and testbench

Line-buffer controller and sequencer for the Sobel convolution datapath. Accepts a raster pixel stream one byte per beat and stores it in four rotating line buffers. Once three full lines are resident, it reads them in lockstep and emits 3x3 windows packed as 72-bit words with a valid strobe, in the exact format the convolution stage consumes. After each output line it releases the oldest line and pulses an interrupt so the upstream DMA can refill.

---
 rtl/sobel_pkg.sv | 33 +++
 rtl/line_buffer.sv | 40 ++++
 rtl/sobel_window_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, FSM state type and width helpers for the Sobel window controller.
package sobel_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_TAPS = 9;
  localparam int unsigned WIN_W    = PIX_W * WIN_TAPS;
  localparam int unsigned N_BUF    = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned TAP_W    = 3 * PIX_W;

  typedef enum logic {
    IDLE,
    RD
  } state_t;

  // Column index width for a line of img_w pixels.
  function automatic int unsigned col_w(input int unsigned img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  // Occupancy width: must hold 0..N_BUF*img_w inclusive.
  function automatic int unsigned occ_w(input int unsigned img_w);
    return $clog2(N_BUF * img_w + 1);
  endfunction

  // Byte k of the window is row k/3, column offset k%3; top row in the low bytes.
  function automatic logic [WIN_W-1:0] pack_window(input logic [TAP_W-1:0] top,
                                                   input logic [TAP_W-1:0] mid,
                                                   input logic [TAP_W-1:0] bot);
    return {bot, mid, top};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One IMG_W x 8 line store: single write port and a registered 3-pixel read at rd_col.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 512,
  localparam int unsigned COL_W = col_w(IMG_W)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_col,
  output logic [TAP_W-1:0] rd_taps
);

  logic [PIX_W-1:0] mem [IMG_W];
  logic [COL_W-1:0] rd_col1;
  logic [COL_W-1:0] rd_col2;

  assign rd_col1 = COL_W'(rd_col + COL_W'(1));
  assign rd_col2 = COL_W'(rd_col + COL_W'(2));

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_col] <= wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_taps <= '0;
    end else if (rd_en) begin
      rd_taps <= {mem[rd_col2], mem[rd_col1], mem[rd_col]};
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Rotating four-line buffer controller: writes a raster stream, reads three lines in
// lockstep and emits packed 3x3 windows, releasing the oldest line after each pass.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 512
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr,
  output logic             o_overflow
);

  localparam int unsigned COL_W = col_w(IMG_W);
  localparam int unsigned OCC_W = occ_w(IMG_W);

  localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] LAST_RD_COL = COL_W'(IMG_W - 3);
  localparam logic [OCC_W-1:0] OCC_LINE    = OCC_W'(IMG_W);
  localparam logic [OCC_W-1:0] OCC_RDY     = OCC_W'(3 * IMG_W);
  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(4 * IMG_W);

  state_t state_q;
  state_t state_d;

  logic [COL_W-1:0] wr_col_q;
  logic [SEL_W-1:0] wr_sel_q;
  logic [COL_W-1:0] rd_col_q;
  logic [SEL_W-1:0] rd_sel_q;
  logic [SEL_W-1:0] win_sel_q;
  logic [OCC_W-1:0] occ_q;

  logic full_c;
  logic wr_fire_c;
  logic rd_en_c;
  logic release_c;

  logic valid_q;
  logic intr_q;
  logic ovf_q;

  logic [TAP_W-1:0] taps [N_BUF];

  assign full_c    = (occ_q == OCC_FULL);
  assign wr_fire_c = i_pixel_data_valid && !full_c;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The extra IDLE beat while o_intr is high keeps adjacent lines at least two
  // invalid cycles apart even when the next line is already resident.
  always_comb begin
    state_d   = state_q;
    rd_en_c   = 1'b0;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if ((occ_q >= OCC_RDY) && !intr_q) begin
          state_d = RD;
        end
      end
      RD: begin
        rd_en_c = 1'b1;
        if (rd_col_q == LAST_RD_COL) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  // Write position: column within the line, then which buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_col_q <= '0;
      wr_sel_q <= '0;
    end else if (wr_fire_c) begin
      if (wr_col_q == LAST_WR_COL) begin
        wr_col_q <= '0;
        wr_sel_q <= SEL_W'(wr_sel_q + SEL_W'(1));
      end else begin
        wr_col_q <= COL_W'(wr_col_q + COL_W'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_col_q <= '0;
      rd_sel_q <= '0;
    end else if (rd_en_c) begin
      if (release_c) begin
        rd_col_q <= '0;
        rd_sel_q <= SEL_W'(rd_sel_q + SEL_W'(1));
      end else begin
        rd_col_q <= COL_W'(rd_col_q + COL_W'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= OCC_W'(occ_q + OCC_W'(wr_fire_c) - (release_c ? OCC_LINE : '0));
    end
  end

  // win_sel_q remembers which buffer was the top row for the taps now in the read registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      win_sel_q <= '0;
    end else begin
      valid_q <= rd_en_c;
      intr_q  <= release_c;
      if (i_pixel_data_valid && full_c) begin
        ovf_q <= 1'b1;
      end
      if (rd_en_c) begin
        win_sel_q <= rd_sel_q;
      end
    end
  end

  for (genvar b = 0; b < N_BUF; b++) begin : g_buf
    logic wr_en_b;
    logic rd_en_b;

    assign wr_en_b = wr_fire_c && (wr_sel_q == SEL_W'(b));
    assign rd_en_b = rd_en_c && (SEL_W'(b) != SEL_W'(rd_sel_q + SEL_W'(3)));

    line_buffer #(
      .IMG_W(IMG_W)
    ) u_line_buffer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .wr_en   (wr_en_b),
      .wr_col  (wr_col_q),
      .wr_data (i_pixel_data),
      .rd_en   (rd_en_b),
      .rd_col  (rd_col_q),
      .rd_taps (taps[b])
    );
  end

  // Rotate the registered taps into top/middle/bottom order; zero outside valid beats.
  always_comb begin
    o_pixel_data = '0;
    if (valid_q) begin
      o_pixel_data = pack_window(taps[win_sel_q],
                                 taps[SEL_W'(win_sel_q + SEL_W'(1))],
                                 taps[SEL_W'(win_sel_q + SEL_W'(2))]);
    end
  end

  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;
  assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl at IMG_W = 8: scenario table plus hand-written corner cases.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int IMG_W = 8;

  logic             i_clk;
  logic             i_rst_n;
  logic [7:0]       i_pixel_data;
  logic             i_pixel_data_valid;
  logic [WIN_W-1:0] o_pixel_data;
  logic             o_pixel_data_valid;
  logic             o_intr;
  logic             o_overflow;

  sobel_window_ctrl #(
    .IMG_W(IMG_W)
  ) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr),
    .o_overflow         (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int n_pix;
    bit gappy;
    int exp_win;
    int exp_intr;
  } vec_t;

  vec_t vecs [5];

  logic [71:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc, intr_cnt, win_cnt, line_win, cyc, e0, first_valid_cyc;
  logic [71:0] first_win, last_win, win19;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int n);
    return 8'(16 * (n / IMG_W) + n % IMG_W);
  endfunction

  // Expected windows for one read pass with top line t.
  task automatic push_line(input int t);
    for (int c = 0; c <= IMG_W - 3; c++) begin
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(16 * (t + k / 3) + c + k % 3);
      exp_q.push_back(w);
    end
  endtask

  task automatic observe();
    if (o_pixel_data_valid) begin
      win_cnt++;
      line_win++;
      if (win_cnt == 1) begin
        first_valid_cyc = cyc;
        first_win = o_pixel_data;
      end
      if (win_cnt == 19) win19 = o_pixel_data;
      last_win = o_pixel_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_window: got %0h expected none", o_pixel_data);
      end else begin
        check("window", o_pixel_data, exp_q.pop_front());
      end
      if (o_intr) begin
        intr_cnt++;
        check("intr_position", 72'(line_win), 72'(IMG_W - 2));
        check("occ_after_release", 72'(dut.occ_q), 72'(acc - IMG_W * intr_cnt));
        line_win = 0;
      end
    end else if (o_intr) begin
      n_checks++;
      n_fail++;
      $display("FAIL intr_without_valid: got intr=1 expected 0");
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    cyc++;
    if (i_rst_n && i_pixel_data_valid && (acc - IMG_W * intr_cnt) < 4 * IMG_W) begin
      acc++;
      if (acc == 3 * IMG_W) e0 = cyc;
      if (acc % IMG_W == 0 && acc >= 3 * IMG_W) push_line(acc / IMG_W - 3);
    end
    @(negedge i_clk);
    observe();
  endtask

  task automatic send(input logic v);
    i_pixel_data_valid = v;
    i_pixel_data = ((acc - IMG_W * intr_cnt) < 4 * IMG_W) ? pix(acc) : 8'hEE;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_pixel_data_valid = 1'b0;
    tick();
    check("rst_data", o_pixel_data, 72'd0);
    check("rst_valid", 72'(o_pixel_data_valid), 72'd0);
    check("rst_intr", 72'(o_intr), 72'd0);
    check("rst_overflow", 72'(o_overflow), 72'd0);
    i_rst_n = 1'b1;
    exp_q.delete();
    acc = 0; intr_cnt = 0; win_cnt = 0; line_win = 0; e0 = 0; first_valid_cyc = 0;
  endtask

  initial begin
    vecs[0] = '{n_pix: 24, gappy: 1'b0, exp_win: 6,  exp_intr: 1};
    vecs[1] = '{n_pix: 64, gappy: 1'b0, exp_win: 36, exp_intr: 6};
    vecs[2] = '{n_pix: 24, gappy: 1'b1, exp_win: 6,  exp_intr: 1};
    vecs[3] = '{n_pix: 23, gappy: 1'b0, exp_win: 0,  exp_intr: 0};
    vecs[4] = '{n_pix: 32, gappy: 1'b1, exp_win: 12, exp_intr: 2};

    i_rst_n = 1'b0;
    i_pixel_data = '0;
    i_pixel_data_valid = 1'b0;
    cyc = 0; acc = 0; intr_cnt = 0;
    idle(2);
    do_reset();

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int p = 0; p < vecs[v].n_pix; p++) begin
        send(1'b1);
        if (vecs[v].gappy) send(1'b0);
      end
      idle(40);
      check("win_count", 72'(win_cnt), 72'(vecs[v].exp_win));
      check("intr_count", 72'(intr_cnt), 72'(vecs[v].exp_intr));
      check("queue_drained", 72'(exp_q.size()), 72'd0);
      check("no_overflow", 72'(o_overflow), 72'd0);
      if (vecs[v].exp_win > 0) check("start_latency", 72'(first_valid_cyc - e0), 72'd2);
      if (v == 0) begin
        check("basic_first", first_win, {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0});
        check("basic_last", last_win, {8'd39, 8'd38, 8'd37, 8'd23, 8'd22, 8'd21, 8'd7, 8'd6, 8'd5});
      end
      if (v == 1) begin
        check("lines345_first", win19, {8'd82, 8'd81, 8'd80, 8'd66, 8'd65, 8'd64, 8'd50, 8'd49, 8'd48});
      end
    end

    // Overflow: reads held off until all four buffers are full, then one extra beat.
    do_reset();
    force dut.state_d = IDLE;
    for (int p = 0; p < 32; p++) send(1'b1);
    check("ovf_before_full", 72'(o_overflow), 72'd0);
    check("occ_full", 72'(dut.occ_q), 72'(acc - IMG_W * intr_cnt));
    send(1'b1);
    check("ovf_set", 72'(o_overflow), 72'd1);
    check("occ_unchanged", 72'(dut.occ_q), 72'd32);
    release dut.state_d;
    idle(30);
    check("ovf_win_count", 72'(win_cnt), 72'd12);
    for (int p = 0; p < IMG_W; p++) send(1'b1);
    idle(30);
    check("ovf_win_count2", 72'(win_cnt), 72'd18);
    check("ovf_sticky", 72'(o_overflow), 72'd1);
    check("ovf_queue", 72'(exp_q.size()), 72'd0);

    // Reset during the third window of a line.
    do_reset();
    for (int p = 0; p < 24; p++) send(1'b1);
    begin
      int waited = 0;
      while (win_cnt < 3 && waited < 20) begin
        send(1'b0);
        waited++;
      end
      check("midreset_reached_3rd", 72'(win_cnt >= 3), 72'd1);
    end
    do_reset();
    idle(20);
    check("midreset_quiet", 72'(win_cnt), 72'd0);
    for (int p = 0; p < 23; p++) send(1'b1);
    idle(10);
    check("midreset_23pix", 72'(win_cnt), 72'd0);
    send(1'b1);
    idle(20);
    check("midreset_refill", 72'(win_cnt), 72'd6);
    check("midreset_queue", 72'(exp_q.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
